// File: rtl/mcs4_pkg.sv
// mcs4 package: common MCS-4 types shared by the CPU, ROM and RAM models.
//   char_t      - 4-bit bus character (nibble)
//   byte_t      - 8-bit instruction byte {OPR, OPA}
//   addr_t      - 12-bit program address
//   instr_cyc_t - 8-slot instruction cycle, A1 = 0 ... X3 = 7
//   next_cyc()  - slot sequencing helper (X3 wraps to A1)
package mcs4;

    localparam int unsigned Pc_width = 12;

    typedef logic [3:0]          char_t;
    typedef logic [7:0]          byte_t;
    typedef logic [Pc_width-1:0] addr_t;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    function automatic instr_cyc_t next_cyc(input instr_cyc_t cur);
        instr_cyc_t nxt;
        case (cur)
            A1:      nxt = A2;
            A2:      nxt = A3;
            A3:      nxt = M1;
            M1:      nxt = M2;
            M2:      nxt = X1;
            X1:      nxt = X2;
            X2:      nxt = X3;
            default: nxt = A1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i4004_fetch_if.sv
// i4004_fetch_if: bus/handshake bundle between the fetch stage and its neighbours.
//   master - fetch stage: drives sync, cm_rom, dbus_out/oe, instr_valid, instr,
//            instr_pc, pc; receives dbus_in, jump_valid, jump_addr, hold.
//   slave  - ROM / decode side: the mirror image.
interface i4004_fetch_if;
    import mcs4::*;

    logic  sync;
    logic  cm_rom;
    char_t dbus_out;
    logic  dbus_oe;
    char_t dbus_in;
    logic  jump_valid;
    addr_t jump_addr;
    logic  hold;
    logic  instr_valid;
    byte_t instr;
    addr_t instr_pc;
    addr_t pc;

    modport master (
        output sync, cm_rom, dbus_out, dbus_oe, instr_valid, instr, instr_pc, pc,
        input  dbus_in, jump_valid, jump_addr, hold
    );

    modport slave (
        input  sync, cm_rom, dbus_out, dbus_oe, instr_valid, instr, instr_pc, pc,
        output dbus_in, jump_valid, jump_addr, hold
    );

endinterface

// File: rtl/i4004_timing.sv
// i4004_timing: 8-slot instruction-cycle counter and slot decode.
//   clk, rst_n  - clock, asynchronous active-low reset (resets to X3)
//   i_clken     - slot-advance enable; low freezes the slot
//   o_icyc      - current slot
//   o_sync      - high in X3
//   o_cm_rom    - high in A3
//   o_dbus_oe   - high in A1..A3
module i4004_timing
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clken,
    output instr_cyc_t o_icyc,
    output logic       o_sync,
    output logic       o_cm_rom,
    output logic       o_dbus_oe
);

    instr_cyc_t r_icyc;
    instr_cyc_t w_icyc_next;

    // Reset lands in X3 so the first enabled edge starts a fresh cycle at A1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icyc <= X3;
        end else begin
            r_icyc <= w_icyc_next;
        end
    end

    always_comb begin
        w_icyc_next = r_icyc;
        o_sync      = 1'b0;
        o_cm_rom    = 1'b0;
        o_dbus_oe   = 1'b0;
        if (i_clken) begin
            w_icyc_next = next_cyc(r_icyc);
        end
        case (r_icyc)
            A1, A2:  o_dbus_oe = 1'b1;
            A3: begin
                o_dbus_oe = 1'b1;
                o_cm_rom  = 1'b1;
            end
            X3:      o_sync = 1'b1;
            default: ;
        endcase
    end

    assign o_icyc = r_icyc;

endmodule

// File: rtl/i4004_fetch.sv
// i4004_fetch: instruction fetch and bus timing stage of the MCS-4 CPU model.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clken       - slot-advance enable; low freezes all state
//   bus         - i4004_fetch_if.master: sync/cm_rom/address nibbles toward the ROM,
//                 returned OPR/OPA nibbles, fetched instruction and PC toward decode,
//                 jump/hold requests from execute.
// Parameter RESET_PC: program counter value after reset.
module i4004_fetch
    import mcs4::*;
#(
    parameter addr_t RESET_PC = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clken,
    i4004_fetch_if.master bus
);

    instr_cyc_t w_icyc;
    logic       w_sync;
    logic       w_cm_rom;
    logic       w_dbus_oe;

    addr_t r_pc;
    char_t r_opr;
    char_t r_opa;
    byte_t r_instr;
    addr_t r_instr_pc;
    logic  r_instr_valid;
    // Set by reset: the first X3->A1 transition must not advance the PC.
    logic  r_first;

    i4004_timing u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clken   (clken),
        .o_icyc    (w_icyc),
        .o_sync    (w_sync),
        .o_cm_rom  (w_cm_rom),
        .o_dbus_oe (w_dbus_oe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_opr         <= 4'h0;
            r_opa         <= 4'h0;
            r_instr       <= 8'h00;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_first       <= 1'b1;
        end else if (clken) begin
            // High exactly for the X1 slot; freezes with clken like everything else.
            r_instr_valid <= (w_icyc == M2);
            case (w_icyc)
                M1: r_opr <= bus.dbus_in;
                M2: begin
                    // OPA is captured on this same edge, so take it straight off the bus.
                    r_opa      <= bus.dbus_in;
                    r_instr    <= {r_opr, bus.dbus_in};
                    r_instr_pc <= r_pc;
                end
                X3: begin
                    r_first <= 1'b0;
                    if (!r_first) begin
                        if (bus.jump_valid) begin
                            r_pc <= bus.jump_addr;
                        end else if (!bus.hold) begin
                            r_pc <= r_pc + 12'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address nibble mux, low nibble first.
    always_comb begin
        bus.dbus_out = 4'h0;
        case (w_icyc)
            A1:      bus.dbus_out = r_pc[3:0];
            A2:      bus.dbus_out = r_pc[7:4];
            A3:      bus.dbus_out = r_pc[11:8];
            default: ;
        endcase
    end

    assign bus.sync        = w_sync;
    assign bus.cm_rom      = w_cm_rom;
    assign bus.dbus_oe     = w_dbus_oe;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.pc          = r_pc;

endmodule

// File: doc/i4004_fetch.md
# i4004_fetch

Instruction-fetch and bus-timing stage of the MCS-4 CPU model: generates the 8-slot instruction cycle, drives `sync` and the 12-bit program address onto the 4-bit data bus as three nibbles, and captures the returned instruction byte. It sits directly upstream of the i4001 ROM model: the ROM consumes `sync`, `cm_rom` and the address nibbles, and returns OPR/OPA nibbles during M1/M2. Fetched instructions go to the CPU decode/execute logic, which steers the program counter through jump/hold requests.

## Interface
Parameters:
- `RESET_PC`, 12'h000, program counter value after reset.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clken` in 1: slot-advance enable; when low, all state holds.
- `sync` out 1: high during slot X3, marks the start of the next instruction cycle.
- `cm_rom` out 1: ROM command line, high during slot A3.
- `dbus_out` out 4 (`mcs4::char_t`): address nibble driven to the bus.
- `dbus_oe` out 1: high while `dbus_out` is valid (A1–A3).
- `dbus_in` in 4 (`mcs4::char_t`): bus data from the ROM.
- `jump_valid` in 1: load `jump_addr` at the next cycle boundary.
- `jump_addr` in 12: jump target.
- `hold` in 1: refetch the same address (no PC increment).
- `instr_valid` out 1: one-`clk` pulse in X1 when a new instruction is presented.
- `instr` out 8 (`mcs4::byte_t`): {OPR, OPA}.
- `instr_pc` out 12: address the instruction was fetched from.
- `pc` out 12: current fetch address.

## Operation
- Slot counter `icyc` (`mcs4::instr_cyc_t`) runs in the order A1, A2, A3, M1, M2, X1, X2, X3, A1 …, advancing one slot per `clk` with `clken`=1.
- Decoded outputs (combinational from `icyc`):
  - `sync` = (X3).
  - `cm_rom` = (A3).
  - `dbus_oe` = (A1|A2|A3).
- `dbus_out` by slot:
  - A1: `pc[3:0]`.
  - A2: `pc[7:4]`.
  - A3: `pc[11:8]`.
  - Any other slot: 4'h0.
- Capture: at the end of M1 (the clock edge leaving M1 with `clken`), `opr <= dbus_in`. At the end of M2, `opa <= dbus_in` and `instr_pc <= pc`.
- Present: on entering X1, `instr <= {opr, dbus_in-captured opa}`, and `instr_valid` is high for exactly the X1 slot. `instr`/`instr_pc` hold until the next X1.
- PC update happens only on the X3→A1 transition. `jump_valid`/`hold` are sampled there, with this priority:
  1. `jump_valid`=1: `pc <= jump_addr`.
  2. Else `hold`=1: `pc` unchanged.
  3. Else `pc <= pc + 1`, modulo 2^12 (12'hFFF wraps to 12'h000; no carry out, no flag).
- `jump_valid`/`hold` in any slot other than X3 are ignored.

## Timing
- Reset values (immediate on `rst_n` low):
  - `icyc` = X3, so `sync`=1, `cm_rom`=0, `dbus_oe`=0, `dbus_out`=0.
  - `pc` = `RESET_PC`.
  - `opr`/`opa`/`instr` = 0, `instr_pc` = 0, `instr_valid` = 0.
- First `clk` edge after `rst_n` release with `clken`=1 enters A1. `pc` is not incremented on this first X3→A1 transition.
- Latency: address issued in A1–A3 → `instr_valid` 5 slots after A1, i.e. in X1 of the same cycle. One instruction per 8 enabled clocks.
- `clken`=0: the slot, all registers and the decoded outputs freeze. An `instr_valid` that is high stays high for the whole frozen X1; downstream must qualify it with `clken`.
- Reset mid-cycle: the partial fetch is abandoned and no `instr_valid` is produced for it.
- `jump_valid` and `hold` both high: jump wins.

## Structure
- The `mcs4` package already carries `char_t`, `byte_t`, `instr_cyc_t` (A1..X3 encoding, A1 = 0). Add `mcs4::addr_t` (12-bit) and `mcs4::Pc_width` = 12 there; `instr_pc`, `jump_addr` and `pc` use `addr_t`.
- Natural sub-module: `i4004_timing`, holding the slot counter plus the `sync`/`cm_rom`/`dbus_oe` decode. The i4004 core reuses it later. PC, capture and the bus mux stay in `i4004_fetch`.

## Test plan
- Reset, then 8 enabled clocks with the ROM returning 0xA (M1) and 0x5 (M2): expect `dbus_out` 0,0,0 in A1–A3 with `dbus_oe`=1, `cm_rom` only in A3, then `instr_valid` for 1 clk with `instr`=8'hA5 and `instr_pc`=0; `sync` high in X3.
- Free-run 3 cycles from reset with `RESET_PC`=12'h123: expect A1/A2/A3 nibbles 3,2,1 then 4,2,1 then 5,2,1.
- `pc`=12'hFFF, free-run: next cycle `pc`=12'h000 and nibbles 0,0,0.
- `jump_valid`=1 with `jump_addr`=12'h7C4 and `hold`=1, both in X3: next A1–A3 drive 4,C,7. The same `jump_valid` pulse in X1 only: ignored, `pc` increments.
- `hold`=1 in X3 across two cycles: the same address is issued twice, with `instr_pc` identical both times.
- `clken` low for 5 clocks inside M1, and separately `rst_n` pulsed low during M2: the first yields the same `instr` with outputs frozen during the gap; the second gives no `instr_valid` and a restart from `RESET_PC` at A1.
